// File: rtl/gpio_int_ctrl.sv
// gpio_int_ctrl: folds the GPIO bank's sticky interrupt status into one processor Irq,
// with a priority vector on acknowledge and a one-cycle per-line clear pulse on EOI.
module gpio_int_ctrl #(
    parameter int HOLDOFF = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [2:0]  Addr,
    output logic [15:0] DataRd,
    input  logic [15:0] DataWr,
    input  logic        En,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [7:0]  IntStatus,
    output logic [7:0]  IntReset,
    output logic        Irq
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ASSERT    = 2'd1,
        INSERVICE = 2'd2,
        CLEAR     = 2'd3
    } stateT;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF);

    stateT      state;
    stateT      nextState;
    logic [7:0] enable;
    logic [7:0] pending;
    logic [7:0] hold;
    logic [7:0] holdDec;
    logic [7:0] intResetNext;
    logic [2:0] active;
    logic [2:0] vec;
    logic       pendingAny;
    logic       vecValid;
    logic       ackRd;
    logic       eoiWr;
    logic       enableWr;
    logic       irqNext;
    logic       unusedDataWr;

    // Bus handshake: an access is En together with Rd or Wr, sampled at a rising Clk edge.
    // There are no wait states; DataRd is combinational from En/Addr in the same cycle.
    assign pending      = IntStatus & enable;
    assign pendingAny   = |pending;
    assign ackRd        = En & Rd & (Addr == 3'd1);
    assign eoiWr        = En & Wr & (Addr == 3'd2);
    assign enableWr     = En & Wr & (Addr == 3'd0);
    assign vecValid     = (state == ASSERT) & pendingAny;
    assign holdDec      = (hold != 8'd0) ? hold - 8'd1 : 8'd0;
    assign unusedDataWr = ^DataWr[15:8];

    // Bit 0 has the highest priority, so scan from the top and let lower bits win.
    always_comb begin
        vec = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) vec = 3'(i);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= nextState;
    end

    // The holdoff decrement taken on this edge counts, so Irq re-asserts HOLDOFF+1 cycles after the pulse.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (pendingAny && (holdDec == 8'd0)) nextState = ASSERT;
            ASSERT:    if (!pendingAny)                     nextState = IDLE;
                       else if (ackRd)                      nextState = INSERVICE;
            INSERVICE: if (eoiWr)                           nextState = CLEAR;
            CLEAR:                                          nextState = IDLE;
            default:                                        nextState = IDLE;
        endcase
    end

    always_comb begin
        irqNext      = (nextState == ASSERT);
        intResetNext = (nextState == CLEAR) ? (8'd1 << active) : 8'd0;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            enable   <= 8'd0;
            active   <= 3'd0;
            hold     <= 8'd0;
            Irq      <= 1'b0;
            IntReset <= 8'd0;
        end else begin
            Irq      <= irqNext;
            IntReset <= intResetNext;
            if (enableWr) enable <= DataWr[7:0];
            if ((state == ASSERT) && ackRd && pendingAny) active <= vec;
            if (state == CLEAR)     hold <= HOLD_LOAD;
            else if (state == IDLE) hold <= holdDec;
        end
    end

    always_comb begin
        DataRd = 16'h0000;
        if (En) begin
            case (Addr)
                3'd0:    DataRd = {8'h00, enable};
                3'd1:    DataRd = vecValid ? {8'h00, 1'b1, 4'b0000, vec} : 16'h0000;
                3'd3:    DataRd = {state, 3'b000, active, pending};
                default: DataRd = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_int_ctrl.sv
// Bench for gpio_int_ctrl: directed scenarios then random register traffic, scored against
// a cycle-level behavioural model of the controller and the GPIO bank.
module tb_gpio_int_ctrl;

  localparam int HOLDOFF = 4;
  localparam int W = 25;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [2:0]  Addr = 3'd0;
  logic [15:0] DataRd;
  logic [15:0] DataWr = 16'h0000;
  logic        En = 1'b0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [7:0]  IntStatus = 8'h00;
  logic [7:0]  IntReset;
  logic        Irq;

  gpio_int_ctrl #(.HOLDOFF(HOLDOFF)) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataRd(DataRd), .DataWr(DataWr),
    .En(En), .Rd(Rd), .Wr(Wr), .IntStatus(IntStatus), .IntReset(IntReset), .Irq(Irq)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // behavioural model: phase 0 idle, 1 irq raised, 2 in service, 3 clearing
  logic [1:0] m_state = 2'd0;
  logic [7:0] m_enable = 8'h00;
  logic [2:0] m_active = 3'd0;
  logic [7:0] bank = 8'h00;
  int         m_last_clear = -1000;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] p);
    for (int i = 0; i < 8; i++) if (p[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_state = 2'd0;
    m_enable = 8'h00;
    m_active = 3'd0;
    m_last_clear = -1000;
  endtask

  // driver: one bus cycle; pushes what the DUT must show during this cycle, then advances the model
  task automatic step(input logic en, input logic rd, input logic wr, input logic [2:0] addr,
                      input logic [15:0] wdata, input logic [7:0] rise);
    logic [7:0]  pend;
    logic        exp_irq;
    logic [7:0]  exp_ir;
    logic [15:0] exp_rd;
    @(posedge Clk);
    #1;
    cyc++;
    bank = bank | rise;
    En = en; Rd = rd; Wr = wr; Addr = addr; DataWr = wdata; IntStatus = bank;
    pend    = bank & m_enable;
    exp_irq = (m_state == 2'd1);
    exp_ir  = (m_state == 2'd3) ? (8'd1 << m_active) : 8'd0;
    exp_rd  = 16'h0000;
    if (en) begin
      case (addr)
        3'd0: exp_rd = {8'h00, m_enable};
        3'd1: exp_rd = (m_state == 2'd1 && pend != 0) ? (16'h0080 | 16'(lowest(pend))) : 16'h0000;
        3'd3: exp_rd = {m_state, 3'b000, m_active, pend};
        default: exp_rd = 16'h0000;
      endcase
    end
    exp_q.push_back({exp_irq, exp_ir, exp_rd});
    case (m_state)
      2'd0: if (pend != 0 && cyc >= m_last_clear + HOLDOFF) m_state = 2'd1;
      2'd1: begin
        if (pend == 0) m_state = 2'd0;
        else if (en && rd && addr == 3'd1) begin
          m_active = lowest(pend);
          m_state = 2'd2;
        end
      end
      2'd2: if (en && wr && addr == 3'd2) m_state = 2'd3;
      default: begin
        m_last_clear = cyc;
        m_state = 2'd0;
      end
    endcase
    if (en && wr && addr == 3'd0) m_enable = wdata[7:0];
    bank = bank & ~exp_ir;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
  endtask

  task automatic async_reset();
    @(posedge Clk);
    #1;
    En = 1'b0; Rd = 1'b0; Wr = 1'b0;
    check("pre_reset_irq", {15'd0, Irq}, {15'd0, m_state == 2'd1});
    check("pre_reset_intreset", {8'd0, IntReset}, (m_state == 2'd3) ? (16'd1 << m_active) : 16'd0);
    #1 Reset = 1'b0;
    #1;
    check("async_reset_irq", {15'd0, Irq}, 16'd0);
    check("async_reset_intreset", {8'd0, IntReset}, 16'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    bank = 8'h00;
    IntStatus = 8'h00;
    Reset = 1'b1;
    model_reset();
  endtask

  // monitor: pops one expectation per driven cycle, away from the active edge
  always @(negedge Clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("irq", {15'd0, Irq}, {15'd0, e[24]});
      check("intreset", {8'd0, IntReset}, {8'd0, e[23:16]});
      check("datard", DataRd, e[15:0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int r;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    // status after reset
    step(1'b1, 1'b1, 1'b0, 3'd3, 16'h0000, 8'h00);
    #1 check("reset_status", DataRd, 16'h0000);

    // lines 3 and 5 raised together; line 3 wins
    step(1'b1, 1'b0, 1'b1, 3'd0, 16'h00FF, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h28);
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    #1 check("irq_latency", {15'd0, Irq}, 16'd1);
    step(1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 8'h00);
    #1 check("vec_line3", DataRd, 16'h0083);
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    #1 check("irq_drop_after_ack", {15'd0, Irq}, 16'd0);
    step(1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 8'h00);
    #1 check("vec_in_service", DataRd, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 3'd2, 16'hFFFF, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    #1 check("eoi_pulse_line3", {8'd0, IntReset}, 16'h0008);
    idle(4);
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    #1 check("irq_after_holdoff", {15'd0, Irq}, 16'd1);
    step(1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 8'h00);
    #1 check("vec_line5", DataRd, 16'h0085);
    step(1'b1, 1'b0, 1'b1, 3'd2, 16'h0000, 8'h00);
    idle(8);

    // masked line stays quiet until enabled
    step(1'b1, 1'b0, 1'b1, 3'd0, 16'h0001, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h80);
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    #1 check("masked_irq", {15'd0, Irq}, 16'd0);
    step(1'b1, 1'b1, 1'b0, 3'd3, 16'h0000, 8'h00);
    #1 check("masked_pending", {8'd0, DataRd[7:0]}, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 3'd0, 16'h0080, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    #1 check("unmasked_irq", {15'd0, Irq}, 16'd1);

    // masking while asserted is spurious: back to idle, no vector, no pulse
    step(1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    step(1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 8'h00);
    #1 check("spurious_irq", {15'd0, Irq}, 16'd0);
    #0 check("spurious_vec", DataRd, 16'h0000);

    // EOI in idle is ignored
    step(1'b1, 1'b0, 1'b1, 3'd2, 16'h0000, 8'h00);
    step(1'b1, 1'b1, 1'b0, 3'd3, 16'h0000, 8'h00);
    #1 check("idle_eoi_pulse", {8'd0, IntReset}, 16'h0000);

    // reset while asserted
    step(1'b1, 1'b0, 1'b1, 3'd0, 16'h0080, 8'h00);
    idle(2);
    async_reset();
    step(1'b1, 1'b1, 1'b0, 3'd3, 16'h0000, 8'h00);
    #1 check("status_after_reset", DataRd, 16'h0000);

    // reset during the clear pulse
    step(1'b1, 1'b0, 1'b1, 3'd0, 16'h00FF, 8'h10);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 8'h00);
    step(1'b1, 1'b0, 1'b1, 3'd2, 16'h0000, 8'h00);
    async_reset();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] rise;
      rise = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2: step(1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, rise);
        3:       step(1'b1, 1'b1, 1'b0, 3'd3, 16'h0000, rise);
        4:       step(1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, rise);
        5:       step(1'b1, 1'b0, 1'b1, 3'd0, 16'($urandom), rise);
        6, 7:    step(1'b1, 1'b0, 1'b1, 3'd2, 16'($urandom), rise);
        8:       step(1'b1, 1'b1, 1'b0, 3'($urandom_range(2, 7)), 16'h0000, rise);
        9:       step(1'b0, 1'b1, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom), rise);
        10:      step(1'b1, 1'b0, 1'b1, 3'($urandom_range(3, 7)), 16'($urandom), rise);
        default: step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, rise);
      endcase
      if (n == 200) async_reset();
    end

    @(negedge Clk);
    #1 check("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
